// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder arbiter: nibble width,
// default operand width and FSM state encodings.
package adder_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4c.sv
// 4-bit combinational adder with carry in and carry out; the single
// arithmetic resource shared by both requesters.
module adder4c (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/adder_arbiter_seq.sv
// Two-requester arbiter sharing one 4-bit adder; WIDTH-bit sums are built
// one nibble per cycle, LSB first. Define ADDER_SAT_EN to saturate on carry out.
module adder_arbiter_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state, next_state;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               id_q;
    logic               last_served;
    logic               grant;
    logic               rdy0, rdy1;
    logic [NIBBLE_W-1:0] nib_s;
    logic               nib_cout;

    adder4c u_adder4c (
        .a    (a_q[idx*NIBBLE_W +: NIBBLE_W]),
        .b    (b_q[idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_comb begin
        next_state = state;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        // On a tie the requester not served last wins.
        if (req0_valid && req1_valid) grant = ~last_served;
        else                          grant = req1_valid;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    rdy0 = req0_valid && !grant;
                    rdy1 = req1_valid && grant;
                end
                if (rdy0 || rdy1) next_state = ADD;
            end
            ADD:  if (idx == IDX_W'(NIBBLES - 1)) next_state = DONE;
            DONE: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            id_q        <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (rdy0 || rdy1) begin
                        a_q         <= grant ? req1_a : req0_a;
                        b_q         <= grant ? req1_b : req0_b;
                        id_q        <= grant;
                        last_served <= grant;
                        idx         <= '0;
                        carry       <= 1'b0;
                    end
                end
                ADD: begin
                    sum_q[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
                    carry <= nib_cout;
                    if (idx == IDX_W'(NIBBLES - 1)) idx <= '0;
                    else                            idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = rdy0;
    assign req1_ready = rdy1;
    assign rsp_valid  = (state == DONE);
    assign rsp_id     = id_q;
    assign rsp_cout   = carry;
`ifdef ADDER_SAT_EN
    assign rsp_sum    = carry ? '1 : sum_q;
`else
    assign rsp_sum    = sum_q;
`endif

endmodule

// File: tb/tb_adder_arbiter_seq.sv
// Directed self-checking bench for adder_arbiter_seq (WIDTH=16).
module tb_adder_arbiter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [15:0] rsp_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    adder_arbiter_seq #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands after accept, check latency and result.
    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic ec, input string tag,
                          output int waited);
        int lat;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        #1;
        waited = 0;
        while (!(id ? req1_ready : req0_ready) && waited < 20) begin tick(); waited++; end
        check({tag, "_accept"}, 32'(waited < 20), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'hDEAD; req0_b = 16'hBEEF; req1_a = 16'hCAFE; req1_b = 16'hF00D;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, rsp_sum, es);
        check({tag, "_cout"}, rsp_cout, ec);
        check({tag, "_id"}, rsp_id, id);
        tick();
        check({tag, "_rsp_drop"}, rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, prev, n;
        logic seen;
        logic [15:0] sat_ffff_p1, sat_8000x2;
`ifdef ADDER_SAT_EN
        sat_ffff_p1 = 16'hFFFF;
        sat_8000x2  = 16'hFFFF;
`else
        sat_ffff_p1 = 16'h0000;
        sat_8000x2  = 16'h0000;
`endif
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset held two cycles with req0 requesting.
        tick();
        check("rst_rdy0_c1", req0_ready, 0);
        check("rst_valid_c1", rsp_valid, 0);
        tick();
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        rst_n = 1'b1;

        run_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, "single", w);
        check("first_edge_accept", w, 0);
        run_op(1'b1, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, "chain_0fff", w);
        run_op(1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, "mixed", w);
        run_op(1'b0, 16'h8000, 16'h8000, sat_8000x2, 1'b1, "top_carry", w);
        run_op(1'b1, 16'hFFFF, 16'h0001, sat_ffff_p1, 1'b1, "chain_ffff", w);

        // Contention: last served is req1, so req0 goes first.
        req0_a = 16'h0001; req0_b = 16'h0002; req1_a = 16'h0010; req1_b = 16'h0020;
        req0_valid = 1'b1; req1_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 30) begin tick(); n++; end
            check("cont_timeout", 32'(n < 30), 1);
            check("cont_id", rsp_id, k % 2);
            check("cont_sum", rsp_sum, (k % 2) ? 16'h0030 : 16'h0003);
            if (k > 0) check("cont_spacing", cyc - prev, 6);
            prev = cyc;
            if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            tick();
        end

        // Backpressure: hold DONE for 3 cycles while req1 waits.
        rsp_ready = 1'b0;
        req0_a = 16'h0F0F; req0_b = 16'hF0F0; req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin tick(); n++; end
        check("bp_accept", 32'(n < 20), 1);
        tick();
        req0_valid = 1'b0; req0_a = 16'h1111;
        req1_a = 16'h0005; req1_b = 16'h0007; req1_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check("bp_latency", n, 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid_hold", rsp_valid, 1);
            check("bp_sum_hold", rsp_sum, 16'hFFFF);
            check("bp_id_hold", rsp_id, 0);
            check("bp_cout_hold", rsp_cout, 0);
            check("bp_rdy1_low", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_exit_valid", rsp_valid, 0);
        check("bp_resume_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check("bp_resume_latency", n, 4);
        check("bp_resume_sum", rsp_sum, 16'h000C);
        check("bp_resume_id", rsp_id, 1);
        tick();

        // Reset while the third nibble is due.
        req0_a = 16'h1111; req0_b = 16'h2222; req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin tick(); n++; end
        check("mid_accept", 32'(n < 20), 1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_sum", rsp_sum, 0);
        check("mid_rst_rdy0", req0_ready, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", seen, 0);
        run_op(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, "post_rst", w);
        check("post_rst_first_edge", w, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
